// File: rtl/eth_rx_mac_filter.sv
// Receive-path destination-address filter for an 8-bit MAC receive stream.
// Buffers the 6-byte destination address, then forwards the frame with a fixed 6-beat delay or discards it.
module eth_rx_mac_filter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic [47:0]            local_mac,
  input  logic                   promiscuous,
  input  logic                   accept_broadcast,
  input  logic                   accept_multicast,
  output logic                   frame_pass,
  output logic                   frame_drop,
  output logic                   rx_overflow,
  output logic [COUNT_WIDTH-1:0] pass_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    PASS  = 3'd2,
    DROP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [8:0]  buf_r [6];          // {tuser, tdata}; entry 0 is the oldest byte
  logic [2:0]  idx_r, idx_s;
  logic [2:0]  drain_cnt_r, drain_cnt_s;
  logic        ovf_r, ovf_s, ovf_next_s;
  logic        shift_in_s, shift_out_s;
  logic        out_valid_s, out_last_s, out_user_s;
  logic        pass_s, drop_s, overflow_s;
  logic [47:0] dest_s;
  logic        accept_s;

  // At the index-5 beat, bytes 0..4 sit in entries 1..5 and byte 5 is on the input
  assign dest_s = {buf_r[1][7:0], buf_r[2][7:0], buf_r[3][7:0],
                   buf_r[4][7:0], buf_r[5][7:0], s_axis_tdata};
  assign accept_s = promiscuous || (dest_s == local_mac) ||
                    (accept_broadcast && (dest_s == 48'hffff_ffff_ffff)) ||
                    (accept_multicast && buf_r[1][0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 3'd0;
      drain_cnt_r <= 3'd0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      drain_cnt_r <= drain_cnt_s;
      ovf_r       <= ovf_s;
    end
  end

  // Next-state, buffer control and output decode
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    drain_cnt_s = drain_cnt_r;
    ovf_s       = ovf_r;
    shift_in_s  = 1'b0;
    shift_out_s = 1'b0;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    out_user_s  = 1'b0;
    pass_s      = 1'b0;
    drop_s      = 1'b0;
    overflow_s  = 1'b0;
    ovf_next_s  = s_axis_tvalid ? !s_axis_tlast : ovf_r;
    case (state_r)
      IDLE: begin
        if (s_axis_tvalid) begin
          shift_in_s = 1'b1;
          if (s_axis_tlast) begin
            drop_s = 1'b1;
          end else begin
            state_s = HDR;
            idx_s   = 3'd1;
          end
        end else begin
          idx_s = 3'd0;
        end
      end
      HDR: begin
        if (s_axis_tvalid) begin
          shift_in_s = 1'b1;
          if (idx_r == 3'd5) begin
            drain_cnt_s = 3'd0;
            if (accept_s) begin
              state_s = s_axis_tlast ? DRAIN : PASS;
            end else if (s_axis_tlast) begin
              drop_s  = 1'b1;
              state_s = IDLE;
            end else begin
              state_s = DROP;
            end
          end else if (s_axis_tlast) begin
            drop_s  = 1'b1;
            state_s = IDLE;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      PASS: begin
        if (s_axis_tvalid) begin
          shift_in_s  = 1'b1;
          out_valid_s = 1'b1;
          if (s_axis_tlast) begin
            state_s     = DRAIN;
            drain_cnt_s = 3'd0;
          end else begin
            state_s = PASS;
          end
        end else begin
          state_s = PASS;
        end
      end
      DRAIN: begin
        shift_out_s = 1'b1;
        out_valid_s = 1'b1;
        // A beat arriving now belongs to a new frame that cannot be buffered
        if (s_axis_tvalid) begin
          overflow_s = 1'b1;
          drop_s     = s_axis_tlast;
        end else begin
          overflow_s = 1'b0;
        end
        if (drain_cnt_r == 3'd5) begin
          out_last_s = 1'b1;
          out_user_s = buf_r[0][8];
          pass_s     = 1'b1;
          state_s    = ovf_next_s ? DROP : IDLE;
          ovf_s      = 1'b0;
        end else begin
          drain_cnt_s = drain_cnt_r + 3'd1;
          ovf_s       = ovf_next_s;
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Byte buffer: shifts in input beats, or shifts out zeros while draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) buf_r[i] <= 9'd0;
    end else if (shift_in_s) begin
      for (int i = 0; i < 5; i++) buf_r[i] <= buf_r[i+1];
      buf_r[5] <= {s_axis_tuser & s_axis_tlast, s_axis_tdata};
    end else if (shift_out_s) begin
      for (int i = 0; i < 5; i++) buf_r[i] <= buf_r[i+1];
      buf_r[5] <= 9'd0;
    end
  end

  // Registered stream outputs, status pulses and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_pass    <= 1'b0;
      frame_drop    <= 1'b0;
      rx_overflow   <= 1'b0;
      pass_count    <= {COUNT_WIDTH{1'b0}};
      drop_count    <= {COUNT_WIDTH{1'b0}};
    end else begin
      m_axis_tdata  <= out_valid_s ? buf_r[0][7:0] : 8'd0;
      m_axis_tvalid <= out_valid_s;
      m_axis_tlast  <= out_last_s;
      m_axis_tuser  <= out_user_s;
      frame_pass    <= pass_s;
      frame_drop    <= drop_s;
      rx_overflow   <= overflow_s;
      if (pass_s && (pass_count != {COUNT_WIDTH{1'b1}}))
        pass_count <= pass_count + COUNT_WIDTH'(1'b1);
      if (drop_s && (drop_count != {COUNT_WIDTH{1'b1}}))
        drop_count <= drop_count + COUNT_WIDTH'(1'b1);
    end
  end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed self-checking bench for eth_rx_mac_filter; a second instance with 2-bit counters checks saturation.
module tb_eth_rx_mac_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic [47:0] local_mac;
  logic        promiscuous, accept_broadcast, accept_multicast;

  logic [7:0]  m_tdata, x_tdata;
  logic        m_tvalid, m_tlast, m_tuser, x_tvalid, x_tlast, x_tuser;
  logic        frame_pass, frame_drop, rx_overflow, x_pass, x_drop, x_ovf;
  logic [15:0] pass_count, drop_count;
  logic [1:0]  x_pass_count, x_drop_count;

  always #5 clk = ~clk;

  eth_rx_mac_filter #(.COUNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .local_mac(local_mac), .promiscuous(promiscuous),
    .accept_broadcast(accept_broadcast), .accept_multicast(accept_multicast),
    .frame_pass(frame_pass), .frame_drop(frame_drop), .rx_overflow(rx_overflow),
    .pass_count(pass_count), .drop_count(drop_count)
  );

  eth_rx_mac_filter #(.COUNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(x_tdata), .m_axis_tvalid(x_tvalid), .m_axis_tlast(x_tlast), .m_axis_tuser(x_tuser),
    .local_mac(local_mac), .promiscuous(promiscuous),
    .accept_broadcast(accept_broadcast), .accept_multicast(accept_multicast),
    .frame_pass(x_pass), .frame_drop(x_drop), .rx_overflow(x_ovf),
    .pass_count(x_pass_count), .drop_count(x_drop_count)
  );

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      oq[$];
  logic [7:0] tx[$];
  logic [7:0] txa[$];
  int cyc = 0;
  int npass = 0, ndrop = 0, novf = 0, pass_cyc = -1, drop_cyc = -1;
  int start_cyc, last_cyc, sa;
  int tests_run = 0, tests_failed = 0;
  int exp_pass = 0, exp_drop = 0;

  localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] MAC_BCAST = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [47:0] MAC_MCAST = 48'h01_00_5e_00_00_01;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (m_tvalid) oq.push_back('{cyc, m_tdata, m_tlast, m_tuser});
    if (frame_pass) begin npass++; pass_cyc = cyc; end
    if (frame_drop) begin ndrop++; drop_cyc = cyc; end
    if (rx_overflow) novf++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [47:0] dst, input int len, input logic bad);
    tx.delete();
    for (int j = 0; j < len; j++) tx.push_back(j < 6 ? dst[47-8*j -: 8] : 8'(j * 7 + 3));
    for (int j = 0; j < len; j++) begin
      @(posedge clk); #1;
      if (j == 0) start_cyc = cyc;
      s_tvalid = 1'b1;
      s_tdata  = tx[j];
      s_tlast  = (j == len - 1);
      s_tuser  = (j == len - 1) && bad;
    end
    last_cyc = cyc;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = 8'd0;
  endtask

  // Expected: output beat k at start+k+7, tlast/tuser only on the final beat
  task automatic check_fwd(input string tag, input int len, input logic bad);
    chk({tag, "_beats"}, oq.size(), len);
    for (int k = 0; k < len && k < oq.size(); k++) begin
      chk({tag, "_data"}, oq[k].d, tx[k]);
      chk({tag, "_last"}, oq[k].l, (k == len - 1));
      chk({tag, "_user"}, oq[k].u, (k == len - 1) && bad);
      chk({tag, "_cyc"}, oq[k].cyc, start_cyc + k + 7);
    end
    chk({tag, "_pass_cyc"}, pass_cyc, last_cyc + 7);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_pass_count"}, pass_count, exp_pass);
    chk({tag, "_drop_count"}, drop_count, exp_drop);
    chk({tag, "_npass"}, npass, exp_pass);
    chk({tag, "_ndrop"}, ndrop, exp_drop);
  endtask

  initial begin
    rst_n = 1'b0; s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    local_mac = MAC_LOCAL; promiscuous = 1'b0; accept_broadcast = 1'b0; accept_multicast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, 8'd0);
    chk("rst_pulses", {frame_pass, frame_drop, rx_overflow, m_tlast, m_tuser}, 5'd0);
    chk("rst_counts", {pass_count, drop_count}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Unicast match, 64 bytes
    oq.delete();
    send(MAC_LOCAL, 64, 1'b0);
    repeat (12) @(posedge clk);
    exp_pass++;
    check_fwd("uni64", 64, 1'b0);
    check_counts("uni64");

    // Address miss and broadcast with nothing enabled
    oq.delete();
    send(MAC_OTHER, 20, 1'b0);
    repeat (3) @(posedge clk);
    exp_drop++;
    chk("miss_drop_cyc", drop_cyc, last_cyc + 1);
    send(MAC_BCAST, 20, 1'b0);
    repeat (10) @(posedge clk);
    exp_drop++;
    chk("bcast_off_beats", oq.size(), 0);
    check_counts("miss");

    accept_broadcast = 1'b1;
    oq.delete();
    send(MAC_BCAST, 20, 1'b0);
    repeat (12) @(posedge clk);
    exp_pass++;
    check_fwd("bcast_on", 20, 1'b0);
    accept_broadcast = 1'b0;

    // Multicast rejected, then accepted
    oq.delete();
    send(MAC_MCAST, 16, 1'b0);
    repeat (10) @(posedge clk);
    exp_drop++;
    chk("mcast_off_beats", oq.size(), 0);
    accept_multicast = 1'b1;
    send(MAC_MCAST, 16, 1'b0);
    repeat (12) @(posedge clk);
    exp_pass++;
    check_fwd("mcast_on", 16, 1'b0);
    accept_multicast = 1'b0;

    // Promiscuous accepts an unmatched unicast
    promiscuous = 1'b1;
    oq.delete();
    send(48'h02_00_00_00_00_09, 12, 1'b0);
    repeat (12) @(posedge clk);
    exp_pass++;
    check_fwd("promisc", 12, 1'b0);
    promiscuous = 1'b0;
    check_counts("mc_prom");

    // Runts: 4 bytes and 1 byte, then exact 6-byte match
    oq.delete();
    send(MAC_LOCAL, 4, 1'b0);
    repeat (3) @(posedge clk);
    exp_drop++;
    chk("runt4_drop_cyc", drop_cyc, last_cyc + 1);
    send(MAC_LOCAL, 1, 1'b0);
    repeat (8) @(posedge clk);
    exp_drop++;
    chk("runt_beats", oq.size(), 0);
    send(MAC_LOCAL, 6, 1'b0);
    repeat (12) @(posedge clk);
    exp_pass++;
    check_fwd("exact6", 6, 1'b0);
    check_counts("runt");

    // Bad frame carries tuser on the last beat only
    oq.delete();
    send(MAC_LOCAL, 20, 1'b1);
    repeat (12) @(posedge clk);
    exp_pass++;
    check_fwd("bad", 20, 1'b1);

    // Overflow: second frame starts 2 cycles after the first tlast
    oq.delete();
    novf = 0;
    send(MAC_LOCAL, 10, 1'b0);
    txa = tx; sa = start_cyc;
    send(MAC_LOCAL, 10, 1'b0);
    repeat (12) @(posedge clk);
    chk("ovf_pulses", novf, 5);
    chk("ovf_drop_cyc", drop_cyc, last_cyc + 1);
    last_cyc = sa + 9;
    tx = txa; start_cyc = sa;
    exp_pass++; exp_drop++;
    check_fwd("ovf_first", 10, 1'b0);
    check_counts("ovf");

    // Reset in the middle of a passing frame
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = (j < 6) ? MAC_LOCAL[47-8*j -: 8] : 8'(j);
      s_tlast  = 1'b0;
    end
    @(posedge clk); #1;
    chk("pre_rst_tvalid", m_tvalid, 1'b1);
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'd0;
    #1;
    chk("midrst_tvalid", m_tvalid, 1'b0);
    chk("midrst_tdata", m_tdata, 8'd0);
    chk("midrst_counts", {pass_count, drop_count}, 32'd0);
    chk("midrst_sat_count", x_pass_count, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    npass = 0; ndrop = 0; exp_pass = 0; exp_drop = 0;
    repeat (2) @(posedge clk);
    oq.delete();
    send(MAC_LOCAL, 8, 1'b0);
    repeat (12) @(posedge clk);
    exp_pass++;
    check_fwd("post_rst", 8, 1'b0);
    check_counts("post_rst");

    // Four more passing frames: 16-bit counter reaches 5, 2-bit counter holds at 3
    for (int f = 0; f < 4; f++) begin
      send(MAC_LOCAL, 6, 1'b0);
      repeat (10) @(posedge clk);
      exp_pass++;
    end
    chk("sat_wide_count", pass_count, exp_pass);
    chk("sat_narrow_count", x_pass_count, 2'd3);
    chk("sat_narrow_drop", x_drop_count, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
